// File: rtl/inst_fetch_queue.sv
//============================================================================
// Module      : inst_fetch_queue
// Description : Circular instruction buffer sitting between the I-cache
//               fetch return and the decode-side slot multiplexer. Every
//               storage slot is exposed in parallel (mux data inputs) and
//               the read pointer is exposed as the mux select, so the mux
//               output is always the oldest queued instruction.
// Optional    : FETCH_QUEUE_STALL_CNT_EN - when defined, stall_cnt counts
//               cycles where fetch offers data while the queue is full
//               (saturating); otherwise stall_cnt is tied to zero.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flush           - redirect, discards all queued entries
//               wr_valid/ready  - fetch-side handshake
//               wr_inst, wr_pc  - fetched instruction and its PC
//               slot_inst       - all storage slots, slot i = entry i
//               rd_sel          - read pointer (mux select)
//               rd_pc           - PC of the entry at rd_sel
//               rd_valid/ready  - decode-side handshake
//               count           - occupied entries, 0..INPUT_SLOT
//               stall_cnt       - fetch stall statistic
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module inst_fetch_queue #(
  parameter int INPUT_SLOT  = 4,
  parameter int INST_LENGTH = 32,
  parameter int PC_LENGTH   = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [INST_LENGTH-1:0]                wr_inst,
  input  logic [PC_LENGTH-1:0]                  wr_pc,
  output logic [INPUT_SLOT-1:0][INST_LENGTH-1:0] slot_inst,
  output logic [$clog2(INPUT_SLOT)-1:0]         rd_sel,
  output logic [PC_LENGTH-1:0]                  rd_pc,
  output logic                                  rd_valid,
  input  logic                                  rd_ready,
  output logic [$clog2(INPUT_SLOT):0]           count,
  output logic [15:0]                           stall_cnt
);

  localparam int c_ptr_w = $clog2(INPUT_SLOT);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(INPUT_SLOT);

  logic [INPUT_SLOT-1:0][INST_LENGTH-1:0] r_slot;
  logic [PC_LENGTH-1:0]                   r_pc [INPUT_SLOT];
  logic [c_ptr_w-1:0]                     r_wr_ptr;
  logic [c_ptr_w-1:0]                     r_rd_ptr;
  logic [c_cnt_w-1:0]                     r_count;

  logic w_wr_ready;
  logic w_rd_valid;
  logic w_push;
  logic w_pop;

  // Handshake flags come from the registered count only, so there is no
  // combinational path between the two sides of the queue. A full queue
  // refuses a push even when a pop happens in the same cycle.
  assign w_wr_ready = (r_count != c_full);
  assign w_rd_valid = (r_count != '0);
  assign w_push     = wr_valid & w_wr_ready;
  assign w_pop      = w_rd_valid & rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_slot   <= '0;
      for (int i = 0; i < INPUT_SLOT; i++) begin
        r_pc[i] <= '0;
      end
    end else if (flush) begin
      // Redirect: only the bookkeeping is reset, stale storage is harmless.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_slot[r_wr_ptr] <= wr_inst;
        r_pc[r_wr_ptr]   <= wr_pc;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (wr_valid && !w_wr_ready && !flush && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0;
`endif

  assign wr_ready  = w_wr_ready;
  assign rd_valid  = w_rd_valid;
  assign rd_sel    = r_rd_ptr;
  assign rd_pc     = r_pc[r_rd_ptr];
  assign count     = r_count;
  assign slot_inst = r_slot;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
//============================================================================
// Module      : tb_inst_fetch_queue
// Description : Self-checking bench for inst_fetch_queue (depth 4). A table
//               of per-cycle vectors covers reset, fill/drain, wrap, full
//               with simultaneous pop and flush; hand-written sequences
//               cover the stall statistic and reset storage clearing.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_inst_fetch_queue;

  localparam int c_slots = 4;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [31:0]             wr_inst;
  logic [31:0]             wr_pc;
  logic [c_slots-1:0][31:0] slot_inst;
  logic [1:0]              rd_sel;
  logic [31:0]             rd_pc;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [2:0]              count;
  logic [15:0]             stall_cnt;

  int checks;
  int errors;

  inst_fetch_queue #(
    .INPUT_SLOT  (c_slots),
    .INST_LENGTH (32),
    .PC_LENGTH   (32)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_inst   (wr_inst),
    .wr_pc     (wr_pc),
    .slot_inst (slot_inst),
    .rd_sel    (rd_sel),
    .rd_pc     (rd_pc),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        wv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rr;
    logic [2:0]  e_cnt;
    logic        e_rv;
    logic        e_wr;
    logic [1:0]  e_sel;
    logic        chk_data;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic wv,
                     input logic [31:0] inst, input logic [31:0] pc, input logic rr,
                     input logic [2:0] e_cnt, input logic e_rv, input logic e_wr,
                     input logic [1:0] e_sel, input logic cd,
                     input logic [31:0] e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.rst = r; v.flush = f; v.wv = wv; v.inst = inst; v.pc = pc; v.rr = rr;
    v.e_cnt = e_cnt; v.e_rv = e_rv; v.e_wr = e_wr; v.e_sel = e_sel;
    v.chk_data = cd; v.e_inst = e_inst; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic wv,
                       input logic [31:0] inst, input logic [31:0] pc, input logic rr);
    rst = r; flush = f; wr_valid = wv; wr_inst = inst; wr_pc = pc; rd_ready = rr;
  endtask

  // Apply the current inputs across one rising edge, sample 1ns later.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    //   rst f  wv inst       pc         rr  cnt rv wr sel cd inst       pc
    // Reset with a push offered: push must be ignored.
    add(1, 0, 1, 32'h99, 32'h900, 0,  0, 0, 1, 0, 1, 32'h0,  32'h0);
    // Fill to full, then a refused fifth push.
    add(0, 0, 1, 32'h11, 32'h100, 0,  1, 1, 1, 0, 1, 32'h11, 32'h100);
    add(0, 0, 1, 32'h22, 32'h104, 0,  2, 1, 1, 0, 1, 32'h11, 32'h100);
    add(0, 0, 1, 32'h33, 32'h108, 0,  3, 1, 1, 0, 1, 32'h11, 32'h100);
    add(0, 0, 1, 32'h44, 32'h10C, 0,  4, 1, 0, 0, 1, 32'h11, 32'h100);
    add(0, 0, 1, 32'h55, 32'h110, 0,  4, 1, 0, 0, 1, 32'h11, 32'h100);
    // Drain in order.
    add(0, 0, 0, 32'h0,  32'h0,   1,  3, 1, 1, 1, 1, 32'h22, 32'h104);
    add(0, 0, 0, 32'h0,  32'h0,   1,  2, 1, 1, 2, 1, 32'h33, 32'h108);
    add(0, 0, 0, 32'h0,  32'h0,   1,  1, 1, 1, 3, 1, 32'h44, 32'h10C);
    add(0, 0, 0, 32'h0,  32'h0,   1,  0, 0, 1, 0, 1, 32'h11, 32'h100);
    // Pop on empty: no pointer move; slot 0 still holds 0x11 (0x55 never written).
    add(0, 0, 0, 32'h0,  32'h0,   1,  0, 0, 1, 0, 1, 32'h11, 32'h100);
    // Wrap: one push, then push+pop pairs.
    add(0, 0, 1, 32'hA1, 32'h200, 0,  1, 1, 1, 0, 1, 32'hA1, 32'h200);
    add(0, 0, 1, 32'hA2, 32'h204, 1,  1, 1, 1, 1, 1, 32'hA2, 32'h204);
    add(0, 0, 1, 32'hA3, 32'h208, 1,  1, 1, 1, 2, 1, 32'hA3, 32'h208);
    add(0, 0, 1, 32'hA4, 32'h20C, 1,  1, 1, 1, 3, 1, 32'hA4, 32'h20C);
    add(0, 0, 1, 32'hA5, 32'h210, 1,  1, 1, 1, 0, 1, 32'hA5, 32'h210);
    add(0, 0, 1, 32'hA6, 32'h214, 1,  1, 1, 1, 1, 1, 32'hA6, 32'h214);
    add(0, 0, 0, 32'h0,  32'h0,   1,  0, 0, 1, 2, 0, 32'h0,  32'h0);
    // Full with simultaneous pop (wr_ptr = rd_ptr = 2 here).
    add(0, 0, 1, 32'hB1, 32'h300, 0,  1, 1, 1, 2, 1, 32'hB1, 32'h300);
    add(0, 0, 1, 32'hB2, 32'h304, 0,  2, 1, 1, 2, 1, 32'hB1, 32'h300);
    add(0, 0, 1, 32'hB3, 32'h308, 0,  3, 1, 1, 2, 1, 32'hB1, 32'h300);
    add(0, 0, 1, 32'hB4, 32'h30C, 0,  4, 1, 0, 2, 1, 32'hB1, 32'h300);
    add(0, 0, 1, 32'hB5, 32'h310, 1,  3, 1, 1, 3, 1, 32'hB2, 32'h304);
    add(0, 0, 1, 32'hB5, 32'h310, 1,  3, 1, 1, 0, 1, 32'hB3, 32'h308);
    add(0, 0, 0, 32'h0,  32'h0,   1,  2, 1, 1, 1, 1, 32'hB4, 32'h30C);
    add(0, 0, 0, 32'h0,  32'h0,   1,  1, 1, 1, 2, 1, 32'hB5, 32'h310);
    // Build count=3, then flush with push and pop asserted.
    add(0, 0, 1, 32'hC1, 32'h400, 0,  2, 1, 1, 2, 1, 32'hB5, 32'h310);
    add(0, 0, 1, 32'hC2, 32'h404, 0,  3, 1, 1, 2, 1, 32'hB5, 32'h310);
    add(0, 1, 1, 32'hDD, 32'h500, 1,  0, 0, 1, 0, 1, 32'hC2, 32'h404);
    add(0, 0, 1, 32'hAA, 32'h600, 0,  1, 1, 1, 0, 1, 32'hAA, 32'h600);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] act_inst;
      drive(vecs[i].rst, vecs[i].flush, vecs[i].wv, vecs[i].inst, vecs[i].pc, vecs[i].rr);
      step();
      chk($sformatf("v%0d count", i),    64'(count),    64'(vecs[i].e_cnt));
      chk($sformatf("v%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].e_rv));
      chk($sformatf("v%0d wr_ready", i), 64'(wr_ready), 64'(vecs[i].e_wr));
      chk($sformatf("v%0d rd_sel", i),   64'(rd_sel),   64'(vecs[i].e_sel));
      if (vecs[i].chk_data) begin
        act_inst = slot_inst[rd_sel];
        chk($sformatf("v%0d rd_inst", i), 64'(act_inst), 64'(vecs[i].e_inst));
        chk($sformatf("v%0d rd_pc", i),   64'(rd_pc),    64'(vecs[i].e_pc));
      end
    end

    // Mid-operation reset (count=1) clears everything, including storage.
    drive(1'b1, 1'b0, 1'b1, 32'h77, 32'h700, 1'b1);
    step();
    chk("rst count", 64'(count), 64'd0);
    chk("rst rd_pc", 64'(rd_pc), 64'd0);
    chk("rst stall", 64'(stall_cnt), 64'd0);
    for (int s = 0; s < c_slots; s++) begin
      logic [31:0] sv;
      sv = slot_inst[s];
      chk($sformatf("rst slot%0d", s), 64'(sv), 64'd0);
    end

    // Fill, then hold wr_valid against a full queue for 10 cycles.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hE0 + 32'(k), 32'h800 + 32'(4 * k), 1'b0);
      step();
    end
    chk("stall full count", 64'(count), 64'd4);
    chk("stall pre", 64'(stall_cnt), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 32'hEF, 32'h8FF, 1'b0);
    for (int k = 0; k < 10; k++) step();
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("stall_cnt after 10", 64'(stall_cnt), 64'd10);
`else
    chk("stall_cnt after 10", 64'(stall_cnt), 64'd0);
`endif
    // Flush cycle while full is not a stall and does not clear the counter.
    drive(1'b0, 1'b1, 1'b1, 32'hEF, 32'h8FF, 1'b0);
    step();
    chk("flush count", 64'(count), 64'd0);
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("stall_cnt after flush", 64'(stall_cnt), 64'd10);
`else
    chk("stall_cnt after flush", 64'(stall_cnt), 64'd0);
`endif

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
